mac_ctrl: RTL and testbench

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_ctrl_valid_delay.sv | 31 +++
 rtl/mac_ctrl.sv | 131 +++++++++++++
 tb/tb_mac_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared FSM state type and MAC latency derivation for mac_ctrl
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    function automatic int mac_latency(input int simd_width);
        return $clog2(simd_width) + 1;
    endfunction

endpackage

// File: rtl/mac_ctrl_valid_delay.sv
// rtl/mac_ctrl_valid_delay.sv - fixed-depth valid tag pipeline with drain detection
module mac_ctrl_valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic empty
);

    // every stage except the output one; empty means the output bit is the last in flight
    localparam logic [DEPTH-1:0] BEHIND_OUT = {DEPTH{1'b1}} >> 1;

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out   = stages[DEPTH-1];
    assign empty = ~in & ~|(stages & BEHIND_OUT);

endmodule

// File: rtl/mac_ctrl.sv
// rtl/mac_ctrl.sv - sequences operand reads into a SIMD MAC and accumulates one signed sum per job
module mac_ctrl
    import mac_pkg::*;
#(
    parameter int SIMD_WIDTH    = 4,
    parameter int MAC_OUT_WIDTH = 34,
    parameter int ACC_WIDTH     = 48,
    parameter int LEN_WIDTH     = 16,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     arst_in,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [LEN_WIDTH-1:0]     cfg_len,
    input  logic [ADDR_WIDTH-1:0]    cfg_base_a,
    input  logic [ADDR_WIDTH-1:0]    cfg_base_b,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr_a,
    output logic [ADDR_WIDTH-1:0]    rd_addr_b,
    output logic                     mac_valid,
    input  logic [MAC_OUT_WIDTH-1:0] mac_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ACC_WIDTH-1:0]     res_data,
    output logic                     busy
);

    localparam int MAC_LATENCY = mac_latency(SIMD_WIDTH);
    localparam int EXT_BITS    = ACC_WIDTH - MAC_OUT_WIDTH;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  state, state_nxt;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat;
    logic [ADDR_WIDTH-1:0]   cur_a, cur_b;
    logic [ADDR_WIDTH-1:0]   last_a, last_b;
    logic [ACC_WIDTH-1:0]    acc;
    logic                    accept;
    logic                    tag;
    logic                    tag_empty;

    assign accept = start_valid & start_ready;

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        rd_en       = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_nxt = (cfg_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                if (beat == len_q - LEN_ONE) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // leave on the same edge that performs the final accumulation
                if (tag_empty) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state     <= IDLE;
            mac_valid <= 1'b0;
            len_q     <= '0;
            beat      <= '0;
            cur_a     <= '0;
            cur_b     <= '0;
            last_a    <= '0;
            last_b    <= '0;
            acc       <= '0;
        end else begin
            state     <= state_nxt;
            mac_valid <= rd_en;
            if (accept) begin
                len_q <= cfg_len;
                beat  <= '0;
                cur_a <= cfg_base_a;
                cur_b <= cfg_base_b;
            end else if (rd_en) begin
                beat   <= beat + LEN_ONE;
                cur_a  <= cur_a + ADDR_ONE;
                cur_b  <= cur_b + ADDR_ONE;
                last_a <= cur_a;
                last_b <= cur_b;
            end
            if (accept) begin
                acc <= '0;
            end else if (tag) begin
                acc <= acc + {{EXT_BITS{mac_out[MAC_OUT_WIDTH-1]}}, mac_out};
            end
        end
    end

    assign rd_addr_a = rd_en ? cur_a : last_a;
    assign rd_addr_b = rd_en ? cur_b : last_b;
    assign res_data  = acc;

    mac_ctrl_valid_delay #(
        .DEPTH (MAC_LATENCY)
    ) u_tag (
        .clk   (clk),
        .rst   (arst_in),
        .in    (mac_valid),
        .out   (tag),
        .empty (tag_empty)
    );

endmodule

// File: tb/tb_mac_ctrl.sv
// tb/tb_mac_ctrl.sv - randomized scoreboard bench for mac_ctrl with an operand buffer and MAC emulator
module tb_mac_ctrl;

    localparam int LAT = $clog2(4) + 1;

    typedef struct {
        logic [47:0] sum;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_in;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] cfg_len;
    logic [15:0] cfg_base_a;
    logic [15:0] cfg_base_b;
    logic        rd_en;
    logic [15:0] rd_addr_a;
    logic [15:0] rd_addr_b;
    logic        mac_valid;
    logic [33:0] mac_out;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] a_mem [65536];
    logic [31:0] b_mem [65536];
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    mac_ctrl dut (
        .clk         (clk),
        .arst_in     (arst_in),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .cfg_len     (cfg_len),
        .cfg_base_a  (cfg_base_a),
        .cfg_base_b  (cfg_base_b),
        .rd_en       (rd_en),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .mac_valid   (mac_valid),
        .mac_out     (mac_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic signed [33:0] dot(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int l = 0; l < 4; l++) begin
            int pa = $signed(a[8*l +: 8]);
            int pb = $signed(b[8*l +: 8]);
            s += pa * pb;
        end
        return 34'(s);
    endfunction

    // operand buffer (1-cycle read) feeding a LAT-cycle MAC; idle slots carry junk
    logic [31:0] rda, rdb;
    logic [33:0] mp [LAT];
    always @(posedge clk) begin
        if (rd_en) begin
            rda <= a_mem[rd_addr_a];
            rdb <= b_mem[rd_addr_b];
        end
        mp[0] <= mac_valid ? dot(rda, rdb) : 34'($urandom);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign mac_out = mp[LAT-1];

    logic prev_rd;
    always @(posedge clk or posedge arst_in) begin
        if (arst_in) prev_rd <= 1'b0;
        else         prev_rd <= rd_en;
    end

    // read-side monitor
    logic [15:0] last_a = '0, last_b = '0;
    always @(negedge clk) begin
        if (arst_in) begin
            last_a = '0;
            last_b = '0;
        end else begin
            chk("mac_valid_align", mac_valid, prev_rd);
            if (addr_q.size() == 0) begin
                chk("rd_en_spurious", rd_en, 1'b0);
            end
            if (rd_en && addr_q.size() != 0) begin
                logic [31:0] e;
                e = addr_q.pop_front();
                chk("rd_addr_a", rd_addr_a, e[31:16]);
                chk("rd_addr_b", rd_addr_b, e[15:0]);
                last_a = e[31:16];
                last_b = e[15:0];
            end else if (!rd_en) begin
                chk("rd_addr_a_hold", rd_addr_a, last_a);
                chk("rd_addr_b_hold", rd_addr_b, last_b);
            end
        end
    end

    // result monitor
    logic        seen = 1'b0;
    logic [47:0] hold;
    always @(negedge clk) begin
        if (arst_in) begin
            seen = 1'b0;
        end else if (res_valid) begin
            chk("busy_in_done", busy, 1'b1);
            chk("start_ready_in_done", start_ready, 1'b0);
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    chk("res_valid_spurious", res_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_data", res_data, e.sum);
                    chk("res_cycle", cyc, e.cyc);
                    hold = e.sum;
                    seen = 1'b1;
                end
            end else begin
                chk("res_data_hold", res_data, hold);
            end
            if (res_ready) seen = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, "_start_ready"}, start_ready, 1'b1);
        chk({tagname, "_busy"}, busy, 1'b0);
        chk({tagname, "_rd_en"}, rd_en, 1'b0);
        chk({tagname, "_mac_valid"}, mac_valid, 1'b0);
        chk({tagname, "_res_valid"}, res_valid, 1'b0);
        chk({tagname, "_res_data"}, res_data, 48'h0);
        chk({tagname, "_rd_addr_a"}, rd_addr_a, 16'h0);
        chk({tagname, "_rd_addr_b"}, rd_addr_b, 16'h0);
    endtask

    task automatic start_job(input int len, input logic [15:0] ba, input logic [15:0] bb);
        int w = 0;
        start_valid = 1'b1;
        cfg_len     = 16'(len);
        cfg_base_a  = ba;
        cfg_base_b  = bb;
        @(negedge clk);
        while (!start_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!start_ready) begin
            chk("accept_timeout", start_ready, 1'b1);
        end else begin
            exp_t        e;
            logic [47:0] s = '0;
            for (int k = 0; k < len; k++) begin
                logic [15:0] aa, bbk;
                longint      d;
                aa  = ba + 16'(k);
                bbk = bb + 16'(k);
                d   = dot(a_mem[aa], b_mem[bbk]);
                s   = s + d[47:0];
                addr_q.push_back({aa, bbk});
            end
            e.sum = s;
            e.cyc = (len == 0) ? cyc + 1 : cyc + len + LAT + 2;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        cfg_len     = 16'($urandom);
        cfg_base_a  = 16'($urandom);
        cfg_base_b  = 16'($urandom);
    endtask

    task automatic finish_job(input int stall);
        int w = 0;
        while (!res_valid && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("res_valid_arrives", res_valid, 1'b1);
        if (stall > 0) begin
            start_valid = 1'b1;
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            start_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic run_job(input int len, input logic [15:0] ba, input logic [15:0] bb, input int stall);
        start_job(len, ba, bb);
        finish_job(stall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            a_mem[i] = $urandom;
            b_mem[i] = $urandom;
        end
        for (int i = 0; i < LAT; i++) mp[i] = '0;
        rda = '0;
        rdb = '0;
        arst_in     = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        cfg_len     = '0;
        cfg_base_a  = '0;
        cfg_base_b  = '0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        arst_in = 1'b0;

        // MAC results 10,20,30,40
        for (int k = 0; k < 4; k++) begin
            a_mem[100 + k] = {24'h0, 8'(10 * (k + 1))};
            b_mem[200 + k] = 32'h0000_0001;
        end
        run_job(4, 16'd100, 16'd200, 0);

        run_job(0, 16'h1234, 16'h4321, 0);

        for (int k = 0; k < 3; k++) begin
            a_mem[300 + k] = 32'h0000_00FF;
            b_mem[400 + k] = 32'h0000_0001;
        end
        run_job(3, 16'd300, 16'd400, 0);

        run_job(5, 16'd1000, 16'd2000, 5);

        run_job(3, 16'hFFFE, 16'h0010, 0);

        // reset during the third issued beat
        start_job(8, 16'd500, 16'd600);
        @(posedge clk);
        @(posedge clk);
        #3;
        arst_in = 1'b1;
        #1;
        check_reset_outputs("mid_job_reset");
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_in = 1'b0;
        a_mem[700] = 32'h0000_0007;
        b_mem[800] = 32'h0000_0001;
        run_job(1, 16'd700, 16'd800, 0);

        for (int j = 0; j < 30; j++) begin
            run_job($urandom_range(0, 20), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
        end

        repeat (10) @(posedge clk);
        #1;
        chk("results_outstanding", exp_q.size(), 0);
        chk("reads_outstanding", addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
